kb_ascii_fifo: RTL and testbench

- Downstream consumer of the PS/2 key-code stage. Captures each released-key scan code, presented as `key_code` qualified by the one-cycle `got_code_tick`.
- Translates set-2 scan codes to ASCII and buffers the result in a small FIFO.
- The application side (LCD/VGA text writer, command parser) pops characters with a read strobe.
- Unmapped scan codes are discarded; overruns raise a sticky flag.

---
 rtl/kb_ascii_fifo_if.sv | 33 +++
 rtl/kb_ascii_fifo.sv | 128 ++++++++++++
 tb/tb_kb_ascii_fifo.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/kb_ascii_fifo_if.sv
// Key-code to ASCII FIFO bus: capture strobe, pop strobe, status flags.
// KB_OVF_CNT_EN adds the saturating overrun counter to the bundle.
interface kb_ascii_fifo_if;
  logic [7:0] key_code;
  logic       got_code_tick;
  logic       rd_ascii;
  logic       clr_ovf;
  logic [7:0] ascii_out;
  logic       empty;
  logic       full;
  logic       overflow;
`ifdef KB_OVF_CNT_EN
  logic [7:0] ovf_count;

  modport slave (
    input  key_code, got_code_tick, rd_ascii, clr_ovf,
    output ascii_out, empty, full, overflow, ovf_count
  );
  modport master (
    output key_code, got_code_tick, rd_ascii, clr_ovf,
    input  ascii_out, empty, full, overflow, ovf_count
  );
`else
  modport slave (
    input  key_code, got_code_tick, rd_ascii, clr_ovf,
    output ascii_out, empty, full, overflow
  );
  modport master (
    output key_code, got_code_tick, rd_ascii, clr_ovf,
    input  ascii_out, empty, full, overflow
  );
`endif
endinterface

// File: rtl/kb_ascii_fifo.sv
// Set-2 scan code -> ASCII translate stage feeding a 2^W_SIZE x 8 FIFO.
// Optional macro KB_OVF_CNT_EN adds a saturating overrun counter (ovf_count).
module kb_ascii_fifo #(
  parameter int W_SIZE = 2
) (
  input  logic           clk,
  input  logic           reset,
  kb_ascii_fifo_if.slave bus
);
  localparam int DEPTH = 1 << W_SIZE;

  logic [7:0]    r_mem [DEPTH];
  logic [W_SIZE:0] r_wr_ptr, r_rd_ptr;
  logic [7:0]    r_ascii;
  logic          r_map_ok;
  logic          r_stage_valid;
  logic          r_overflow;

  logic [7:0]    w_map;
  logic          w_map_ok;
  logic          w_empty, w_full, w_pop, w_wr, w_drop;

  always_comb begin
    w_map    = 8'h00;
    w_map_ok = 1'b1;
    case (bus.key_code)
      8'h45: w_map = 8'h30;
      8'h16: w_map = 8'h31;
      8'h1E: w_map = 8'h32;
      8'h26: w_map = 8'h33;
      8'h25: w_map = 8'h34;
      8'h2E: w_map = 8'h35;
      8'h36: w_map = 8'h36;
      8'h3D: w_map = 8'h37;
      8'h3E: w_map = 8'h38;
      8'h46: w_map = 8'h39;
      8'h1C: w_map = 8'h41;
      8'h32: w_map = 8'h42;
      8'h21: w_map = 8'h43;
      8'h23: w_map = 8'h44;
      8'h24: w_map = 8'h45;
      8'h2B: w_map = 8'h46;
      8'h34: w_map = 8'h47;
      8'h33: w_map = 8'h48;
      8'h43: w_map = 8'h49;
      8'h3B: w_map = 8'h4A;
      8'h42: w_map = 8'h4B;
      8'h4B: w_map = 8'h4C;
      8'h3A: w_map = 8'h4D;
      8'h31: w_map = 8'h4E;
      8'h44: w_map = 8'h4F;
      8'h4D: w_map = 8'h50;
      8'h15: w_map = 8'h51;
      8'h2D: w_map = 8'h52;
      8'h1B: w_map = 8'h53;
      8'h2C: w_map = 8'h54;
      8'h3C: w_map = 8'h55;
      8'h2A: w_map = 8'h56;
      8'h1D: w_map = 8'h57;
      8'h22: w_map = 8'h58;
      8'h35: w_map = 8'h59;
      8'h1A: w_map = 8'h5A;
      8'h29: w_map = 8'h20;
      8'h5A: w_map = 8'h0D;
      8'h66: w_map = 8'h08;
      default: w_map_ok = 1'b0;
    endcase
  end

  // Full: same slot index, opposite lap bit.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[W_SIZE-1:0] == r_rd_ptr[W_SIZE-1:0]) &&
                   (r_wr_ptr[W_SIZE] != r_rd_ptr[W_SIZE]);
  assign w_pop   = bus.rd_ascii & ~w_empty;
  // A same-edge pop frees the slot, so a full FIFO still accepts the write.
  assign w_wr    = r_stage_valid & r_map_ok & (~w_full | w_pop);
  assign w_drop  = r_stage_valid & r_map_ok & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage_valid <= 1'b0;
      r_map_ok      <= 1'b0;
      r_ascii       <= 8'h00;
    end else begin
      r_stage_valid <= bus.got_code_tick;
      if (bus.got_code_tick) begin
        r_ascii  <= w_map;
        r_map_ok <= w_map_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop)           r_overflow <= 1'b1;
      else if (bus.clr_ovf) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_wr) r_mem[r_wr_ptr[W_SIZE-1:0]] <= r_ascii;
  end

`ifdef KB_OVF_CNT_EN
  logic [7:0] r_ovf_count;

  always_ff @(posedge clk) begin
    if (reset)                  r_ovf_count <= 8'h00;
    else if (w_drop) begin
      if (bus.clr_ovf)          r_ovf_count <= 8'h01;
      else if (r_ovf_count != 8'hFF) r_ovf_count <= r_ovf_count + 8'h01;
    end else if (bus.clr_ovf)   r_ovf_count <= 8'h00;
  end

  assign bus.ovf_count = r_ovf_count;
`endif

  assign bus.ascii_out = r_mem[r_rd_ptr[W_SIZE-1:0]];
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_kb_ascii_fifo.sv
// Scoreboard bench for kb_ascii_fifo: driver queues expected ASCII, monitor checks pops.
module tb_kb_ascii_fifo;
  logic clk = 1'b0;
  logic reset;
  kb_ascii_fifo_if bus ();

  kb_ascii_fifo #(.W_SIZE(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected character.
  always @(negedge clk) begin
    if (!reset && bus.rd_ascii && bus.empty === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_unexpected: got %02h expected no data", bus.ascii_out);
      end else begin
        chk("pop_data", bus.ascii_out, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Tick one scan code; queue its ASCII only if the FIFO is expected to keep it.
  task automatic tick(input logic [7:0] code, input bit keep, input logic [7:0] exp);
    bus.key_code      = code;
    bus.got_code_tick = 1'b1;
    if (keep) exp_q.push_back(exp);
    cyc();
    bus.got_code_tick = 1'b0;
  endtask

  task automatic pop(input int n);
    bus.rd_ascii = 1'b1;
    cyc(n);
    bus.rd_ascii = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    exp_q.delete();
  endtask

  localparam logic [7:0] FILL_CODE [4] = '{8'h1C, 8'h32, 8'h21, 8'h23};
  localparam logic [7:0] FILL_ASC  [4] = '{8'h41, 8'h42, 8'h43, 8'h44};

  task automatic fill4();
    for (int i = 0; i < 4; i++) tick(FILL_CODE[i], 1'b1, FILL_ASC[i]);
    cyc();
  endtask

  initial begin
    reset             = 1'b1;
    bus.key_code      = 8'h00;
    bus.got_code_tick = 1'b0;
    bus.rd_ascii      = 1'b0;
    bus.clr_ovf       = 1'b0;
    cyc(2);
    reset = 1'b0;

    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_ovf", bus.overflow, 0);

    // Single key: one edge after the tick the entry is still in the translate stage.
    tick(8'h1C, 1'b1, 8'h41);
    chk("lat_empty_e0", bus.empty, 1);
    cyc();
    chk("lat_empty_e1", bus.empty, 0);
    chk("head_A", bus.ascii_out, 8'h41);
    pop(1);
    chk("empty_after_pop", bus.empty, 1);

    // Back-to-back ticks.
    bus.got_code_tick = 1'b1;
    bus.key_code = 8'h16; exp_q.push_back(8'h31); cyc();
    bus.key_code = 8'h1E; exp_q.push_back(8'h32); cyc();
    bus.key_code = 8'h45; exp_q.push_back(8'h30); cyc();
    bus.got_code_tick = 1'b0;
    cyc();
    pop(3);
    chk("empty_after_3", bus.empty, 1);

    // Unmapped code and pop while empty are both ignored.
    tick(8'h76, 1'b0, 8'h00);
    cyc(2);
    chk("unmapped_empty", bus.empty, 1);
    chk("unmapped_ovf", bus.overflow, 0);
    pop(1);
    chk("pop_empty_ign", bus.empty, 1);
    tick(8'h5A, 1'b1, 8'h0D);
    cyc();
    chk("enter_head", bus.ascii_out, 8'h0D);
    pop(1);

    // Fill, then overrun.
    for (int i = 0; i < 4; i++) begin
      tick(FILL_CODE[i], 1'b1, FILL_ASC[i]);
      cyc();
      if (i == 2) chk("not_full_3", bus.full, 0);
    end
    chk("full_4", bus.full, 1);
    chk("no_ovf_4", bus.overflow, 0);
    tick(8'h24, 1'b0, 8'h00);
    cyc();
    chk("ovf_5", bus.overflow, 1);
    chk("full_5", bus.full, 1);
    bus.clr_ovf = 1'b1; cyc(); bus.clr_ovf = 1'b0;
    chk("ovf_clr", bus.overflow, 0);
    pop(4);
    chk("empty_drain", bus.empty, 1);

    // Write and pop on the same edge while full.
    fill4();
    tick(8'h1A, 1'b1, 8'h5A);
    pop(1);
    chk("wp_full", bus.full, 1);
    chk("wp_ovf", bus.overflow, 0);
    pop(4);
    chk("wp_empty", bus.empty, 1);

    // Overrun set beats a same-edge clear.
    fill4();
    tick(8'h29, 1'b0, 8'h00);
    bus.clr_ovf = 1'b1; cyc(); bus.clr_ovf = 1'b0;
    chk("set_wins", bus.overflow, 1);
    pop(4);

`ifdef KB_OVF_CNT_EN
    bus.clr_ovf = 1'b1; cyc(); bus.clr_ovf = 1'b0;
    chk("cnt_clr0", bus.ovf_count, 8'h00);
    fill4();
    for (int i = 0; i < 6; i++) tick(8'h2C, 1'b0, 8'h00);
    cyc();
    chk("cnt_6", bus.ovf_count, 8'h06);
    tick(8'h2C, 1'b0, 8'h00);
    bus.clr_ovf = 1'b1; cyc(); bus.clr_ovf = 1'b0;
    chk("cnt_clr_inc", bus.ovf_count, 8'h01);
    bus.clr_ovf = 1'b1; cyc(); bus.clr_ovf = 1'b0;
    chk("cnt_clr", bus.ovf_count, 8'h00);
    pop(4);
`endif

    // Reset with a pending translate-stage entry and sticky flag set.
    fill4();
    tick(8'h24, 1'b0, 8'h00);
    cyc();
    chk("pre_rst_ovf", bus.overflow, 1);
    pop(1);
    tick(8'h2C, 1'b0, 8'h00);
    reset = 1'b1; cyc(); reset = 1'b0;
    exp_q.delete();
    cyc(3);
    chk("rst_mid_empty", bus.empty, 1);
    chk("rst_mid_full", bus.full, 0);
    chk("rst_mid_ovf", bus.overflow, 0);
`ifdef KB_OVF_CNT_EN
    chk("rst_mid_cnt", bus.ovf_count, 8'h00);
`endif

    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
